// File: rtl/periph_vga_scanout_pkg.sv
// rtl/periph_vga_scanout_pkg.sv - shared constants and colour expansion for the VGA scanout
package periph_vga_scanout_pkg;

  // Default 640x480@60 timing
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  // Framebuffer geometry: enough address bits for an unscaled 640x480 frame
  localparam int VGA_FB_ADDR_WIDTH = 19;
  localparam int VGA_FB_PIX_WIDTH  = 12;

  // Replicate a right-aligned bpc-bit channel MSB-first until 4 bits are filled
  function automatic logic [3:0] expand_channel(input logic [3:0] c, input int bpc);
    logic [3:0] r;
    logic [1:0] src;
    logic [1:0] dst;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      src    = 2'(bpc - 1 - (i % bpc));
      dst    = 2'(3 - i);
      r[dst] = c[src];
    end
    return r;
  endfunction

endpackage

// File: rtl/periph_vga_scanout_timing.sv
// rtl/periph_vga_scanout_timing.sv - programmable VGA horizontal/vertical timing counters
module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW       = $clog2(H_TOTAL + 1),
  localparam int VW       = $clog2(V_TOTAL + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  output logic [HW-1:0] h_cnt_o,
  output logic [VW-1:0] v_cnt_o,
  output logic          de_o,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          line_end_o,
  output logic          frame_end_o
);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;

  // Horizontal count wraps at line end; vertical count steps on each wrap
  always_comb begin
    h_cnt_d = h_cnt_q + HW'(1);
    v_cnt_d = v_cnt_q;
    if (line_end_o) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VW'(1);
    end
  end

  // Counter registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign h_cnt_o     = h_cnt_q;
  assign v_cnt_o     = v_cnt_q;
  assign line_end_o  = (h_cnt_q == H_LAST);
  assign frame_end_o = line_end_o && (v_cnt_q == V_LAST);
  assign de_o        = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
  assign hsync_o     = ((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
  assign vsync_o     = ((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END)) ? VSYNC_POL : ~VSYNC_POL;

endmodule

// File: rtl/periph_vga_scanout.sv
// rtl/periph_vga_scanout.sv - framebuffer scanout with scaling, double buffer and colour expansion
module periph_vga_scanout
  import periph_vga_scanout_pkg::*;
#(
  parameter int H_ACTIVE      = VGA_H_ACTIVE,
  parameter int H_FP          = VGA_H_FP,
  parameter int H_SYNC        = VGA_H_SYNC,
  parameter int H_BP          = VGA_H_BP,
  parameter int V_ACTIVE      = VGA_V_ACTIVE,
  parameter int V_FP          = VGA_V_FP,
  parameter int V_SYNC        = VGA_V_SYNC,
  parameter int V_BP          = VGA_V_BP,
  parameter bit HSYNC_POL     = 1'b0,
  parameter bit VSYNC_POL     = 1'b0,
  parameter int SCALE_LOG2    = 1,
  parameter int BPC           = 4,
  parameter int FB_ADDR_WIDTH = VGA_FB_ADDR_WIDTH,
  parameter int RD_LAT        = 1
) (
  input  logic                     CLK,
  input  logic                     RST_X,
  input  logic                     i_enable,
  input  logic [11:0]              i_bg_color,
  input  logic [FB_ADDR_WIDTH-1:0] i_fb_base,
  output logic [FB_ADDR_WIDTH-1:0] o_fb_raddr,
  input  logic [3*BPC-1:0]         i_fb_rdata,
  output logic                     vga_h_sync,
  output logic                     vga_v_sync,
  output logic [3:0]               vga_red,
  output logic [3:0]               vga_green,
  output logic [3:0]               vga_blue,
  output logic                     o_vblank_irq
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);
  localparam int FW      = H_ACTIVE >> SCALE_LOG2;

  localparam logic [HW-1:0]            H_SUB_MASK = HW'((1 << SCALE_LOG2) - 1);
  localparam logic [VW-1:0]            V_SUB_MASK = VW'((1 << SCALE_LOG2) - 1);
  localparam logic [VW-1:0]            V_ACT      = VW'(V_ACTIVE);
  localparam logic [FB_ADDR_WIDTH-1:0] FW_STEP    = FB_ADDR_WIDTH'(FW);

  if (SCALE_LOG2 < 0 || SCALE_LOG2 > 2) begin : g_bad_scale
    $error("periph_vga_scanout: SCALE_LOG2 must be 0..2");
  end
  if (BPC < 1 || BPC > 4) begin : g_bad_bpc
    $error("periph_vga_scanout: BPC must be 1..4");
  end
  if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_lat
    $error("periph_vga_scanout: RD_LAT must be 1..3");
  end

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          de, hsync, vsync, line_end, frame_end;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .HSYNC_POL(HSYNC_POL),
    .VSYNC_POL(VSYNC_POL)
  ) u_timing (
    .clk_i      (CLK),
    .rst_ni     (RST_X),
    .h_cnt_o    (h_cnt),
    .v_cnt_o    (v_cnt),
    .de_o       (de),
    .hsync_o    (hsync),
    .vsync_o    (vsync),
    .line_end_o (line_end),
    .frame_end_o(frame_end)
  );

  logic [FB_ADDR_WIDTH-1:0] row_q, row_d;
  logic [FB_ADDR_WIDTH-1:0] col_q, col_d;
  logic [FB_ADDR_WIDTH-1:0] base_q, base_d;
  logic [FB_ADDR_WIDTH-1:0] hold_q, hold_d;
  logic [FB_ADDR_WIDTH-1:0] cur_addr;
  logic                     vblank_start;

  assign cur_addr     = row_q + col_q;
  assign vblank_start = (h_cnt == '0) && (v_cnt == V_ACT);

  // Address walk: col steps once per scaled pixel, row steps after the last repeat of a line
  always_comb begin
    row_d  = row_q;
    col_d  = col_q;
    base_d = base_q;
    hold_d = hold_q;
    if (line_end) begin
      col_d = '0;
    end else if (de && ((h_cnt & H_SUB_MASK) == H_SUB_MASK)) begin
      col_d = col_q + FB_ADDR_WIDTH'(1);
    end
    if (frame_end) begin
      row_d = base_q;
    end else if (line_end && (v_cnt < V_ACT) && ((v_cnt & V_SUB_MASK) == V_SUB_MASK)) begin
      row_d = row_q + FW_STEP;
    end
    if (vblank_start) begin
      base_d = i_fb_base;
    end
    if (de) begin
      hold_d = cur_addr;
    end
  end

  // Address and frame-base registers
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      row_q  <= '0;
      col_q  <= '0;
      base_q <= '0;
      hold_q <= '0;
    end else begin
      row_q  <= row_d;
      col_q  <= col_d;
      base_q <= base_d;
      hold_q <= hold_d;
    end
  end

  // The last active address stays on the bus through blanking
  assign o_fb_raddr   = de ? cur_addr : hold_q;
  assign o_vblank_irq = vblank_start;

  logic [RD_LAT:0] de_pipe_q;
  logic [RD_LAT:0] hs_pipe_q;
  logic [RD_LAT:0] vs_pipe_q;

  // Delay de and syncs so they line up with the registered colour
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      de_pipe_q <= '0;
      hs_pipe_q <= {(RD_LAT+1){~HSYNC_POL}};
      vs_pipe_q <= {(RD_LAT+1){~VSYNC_POL}};
    end else begin
      de_pipe_q <= {de_pipe_q[RD_LAT-1:0], de};
      hs_pipe_q <= {hs_pipe_q[RD_LAT-1:0], hsync};
      vs_pipe_q <= {vs_pipe_q[RD_LAT-1:0], vsync};
    end
  end

  logic [3:0]  fb_r, fb_g, fb_b;
  logic [11:0] rgb_q, rgb_d;

  assign fb_r = 4'(i_fb_rdata[3*BPC-1 -: BPC]);
  assign fb_g = 4'(i_fb_rdata[2*BPC-1 -: BPC]);
  assign fb_b = 4'(i_fb_rdata[BPC-1:0]);

  // Pick black, background or expanded framebuffer pixel for the word arriving now
  always_comb begin
    rgb_d = '0;
    if (de_pipe_q[RD_LAT-1]) begin
      if (!i_enable) begin
        rgb_d = i_bg_color;
      end else begin
        rgb_d = {expand_channel(fb_r, BPC), expand_channel(fb_g, BPC), expand_channel(fb_b, BPC)};
      end
    end
  end

  // Colour output register
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      rgb_q <= '0;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  assign vga_red    = rgb_q[11:8];
  assign vga_green  = rgb_q[7:4];
  assign vga_blue   = rgb_q[3:0];
  assign vga_h_sync = hs_pipe_q[RD_LAT];
  assign vga_v_sync = vs_pipe_q[RD_LAT];

endmodule

// File: tb/tb_periph_vga_scanout.sv
// tb/tb_periph_vga_scanout.sv - directed bench for periph_vga_scanout
module tb_periph_vga_scanout;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Default 640x480 instance, RD_LAT=1, SCALE_LOG2=1, BPC=4
  logic        rst_a, a_en, a_hs, a_vs, a_irq;
  logic [11:0] a_bg, a_rd;
  logic [18:0] a_base, a_raddr;
  logic [3:0]  a_r, a_g, a_b;
  wire  [11:0] a_rgb = {a_r, a_g, a_b};

  periph_vga_scanout u_dut_a (
    .CLK(clk), .RST_X(rst_a), .i_enable(a_en), .i_bg_color(a_bg), .i_fb_base(a_base),
    .o_fb_raddr(a_raddr), .i_fb_rdata(a_rd), .vga_h_sync(a_hs), .vga_v_sync(a_vs),
    .vga_red(a_r), .vga_green(a_g), .vga_blue(a_b), .o_vblank_irq(a_irq)
  );
  always @(posedge clk) a_rd <= a_raddr[11:0] ^ 12'h3C5;

  // Small frame 24x14 total, 16x8 active, SCALE_LOG2=1, BPC=3, RD_LAT=2
  logic        rst_s, s_en, s_hs, s_vs, s_irq;
  logic [11:0] s_bg;
  logic [8:0]  s_p1, s_rd;
  logic [18:0] s_base, s_raddr;
  logic [3:0]  s_r, s_g, s_b;
  wire  [11:0] s_rgb = {s_r, s_g, s_b};

  periph_vga_scanout #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .SCALE_LOG2(1), .BPC(3), .RD_LAT(2)
  ) u_dut_s (
    .CLK(clk), .RST_X(rst_s), .i_enable(s_en), .i_bg_color(s_bg), .i_fb_base(s_base),
    .o_fb_raddr(s_raddr), .i_fb_rdata(s_rd), .vga_h_sync(s_hs), .vga_v_sync(s_vs),
    .vga_red(s_r), .vga_green(s_g), .vga_blue(s_b), .o_vblank_irq(s_irq)
  );
  always @(posedge clk) begin
    s_p1 <= s_raddr[8:0] ^ 9'h157;
    s_rd <= s_p1;
  end

  // Same small frame, SCALE_LOG2=0, BPC=4, RD_LAT=3
  logic        rst_l, l_hs, l_vs, l_irq;
  logic [11:0] l_p1, l_p2, l_rd;
  logic [18:0] l_base, l_raddr;
  logic [3:0]  l_r, l_g, l_b;
  wire  [11:0] l_rgb = {l_r, l_g, l_b};

  periph_vga_scanout #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .SCALE_LOG2(0), .BPC(4), .RD_LAT(3)
  ) u_dut_l (
    .CLK(clk), .RST_X(rst_l), .i_enable(1'b1), .i_bg_color(12'h000), .i_fb_base(l_base),
    .o_fb_raddr(l_raddr), .i_fb_rdata(l_rd), .vga_h_sync(l_hs), .vga_v_sync(l_vs),
    .vga_red(l_r), .vga_green(l_g), .vga_blue(l_b), .o_vblank_irq(l_irq)
  );
  always @(posedge clk) begin
    l_p1 <= l_raddr[11:0] ^ 12'hA5C;
    l_p2 <= l_p1;
    l_rd <= l_p2;
  end

  task automatic run_to(input int n);
    while (cyc < n) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests++; if (a_rgb !== 12'h000) begin fails++; $display("FAIL reset_a_rgb: got %h want 000", a_rgb); end
    tests++; if (a_hs !== 1'b1) begin fails++; $display("FAIL reset_a_hsync: got %b want 1", a_hs); end
    tests++; if (a_vs !== 1'b1) begin fails++; $display("FAIL reset_a_vsync: got %b want 1", a_vs); end
    tests++; if (a_irq !== 1'b0) begin fails++; $display("FAIL reset_a_irq: got %b want 0", a_irq); end
    tests++; if (a_raddr !== 19'd0) begin fails++; $display("FAIL reset_a_raddr: got %0d want 0", a_raddr); end
    tests++; if (s_rgb !== 12'h000) begin fails++; $display("FAIL reset_s_rgb: got %h want 000", s_rgb); end
    tests++; if (l_hs !== 1'b1) begin fails++; $display("FAIL reset_l_hsync: got %b want 1", l_hs); end
  endtask

  task automatic test_default_timing();
    int hs_err = 0, vs_err = 0, ra_err = 0, px_err = 0;
    int hs_first = -1, ra_first = -1, px_first = -1;
    int fall1 = -1, fall2 = -1;
    logic prev_hs = 1'b1;
    logic exp_hs;
    logic [18:0] ra1600 = '0;
    logic [11:0] px1 = '0, px2 = '0, exp_px;
    int h, ln;
    rst_a = 1'b1;
    for (int c = 0; c <= 1700; c++) begin
      if (c > 0) @(negedge clk);
      exp_hs = 1'b1;
      if (c >= 2 && ((c - 2) % 800) >= 656 && ((c - 2) % 800) < 752) exp_hs = 1'b0;
      if (a_hs !== exp_hs) begin if (hs_err == 0) hs_first = c; hs_err++; end
      if (a_vs !== 1'b1) vs_err++;
      if (prev_hs === 1'b1 && a_hs === 1'b0) begin
        if (fall1 < 0) fall1 = c; else if (fall2 < 0) fall2 = c;
      end
      prev_hs = a_hs;
      h = c % 800; ln = c / 800;
      if (ln < 2 && h < 640) begin
        if (a_raddr !== 19'((ln >> 1) * 320 + (h >> 1))) begin if (ra_err == 0) ra_first = c; ra_err++; end
      end
      if (c == 1600) ra1600 = a_raddr;
      exp_px = 12'h000;
      if (c >= 2) begin
        h = (c - 2) % 800; ln = (c - 2) / 800;
        if (h < 640) exp_px = 12'((ln >> 1) * 320 + (h >> 1)) ^ 12'h3C5;
      end
      if (a_rgb !== exp_px) begin if (px_err == 0) px_first = c; px_err++; end
      if (c == 1) px1 = a_rgb;
      if (c == 2) px2 = a_rgb;
    end
    tests++; if (hs_err != 0) begin fails++; $display("FAIL hsync_window: %0d bad cycles, first at %0d, want 0", hs_err, hs_first); end
    tests++; if (vs_err != 0) begin fails++; $display("FAIL vsync_idle: %0d bad cycles, want 0", vs_err); end
    tests++; if (fall1 != 658) begin fails++; $display("FAIL hsync_first_fall: got %0d want 658", fall1); end
    tests++; if (fall2 - fall1 != 800) begin fails++; $display("FAIL hsync_period: got %0d want 800", fall2 - fall1); end
    tests++; if (ra_err != 0) begin fails++; $display("FAIL addr_lines01: %0d bad cycles, first at %0d, want 0", ra_err, ra_first); end
    tests++; if (ra1600 !== 19'd320) begin fails++; $display("FAIL addr_line2_start: got %0d want 320", ra1600); end
    tests++; if (px1 !== 12'h000) begin fails++; $display("FAIL lat1_pre_pixel: got %h want 000", px1); end
    tests++; if (px2 !== 12'h3C5) begin fails++; $display("FAIL lat1_first_pixel: got %h want 3c5", px2); end
    tests++; if (px_err != 0) begin fails++; $display("FAIL lat1_pixels: %0d bad cycles, first at %0d, want 0", px_err, px_first); end
  endtask

  task automatic test_double_buffer();
    int          ra_c [0:10] = '{0, 2, 15, 16, 24, 48, 144, 183, 192, 336, 338};
    logic [18:0] ra_e [0:10] = '{19'd0, 19'd1, 19'd7, 19'd7, 19'd0, 19'd8, 19'd24, 19'd31, 19'd31,
                                 19'h12C00, 19'h12C01};
    int          sp_c [0:5]  = '{2, 3, 5, 7, 19, 339};
    logic [11:0] sp_e [0:5]  = '{12'h000, 12'hB4F, 12'hB4D, 12'hB4B, 12'h000, 12'hB4F};
    int          lp_c [0:4]  = '{3, 4, 5, 20, 28};
    logic [11:0] lp_e [0:4]  = '{12'h000, 12'hA5C, 12'hA5D, 12'h000, 12'hA4C};
    int irq_cnt = 0, irq_at = -1, vs_err = 0, hs_err = 0;
    logic exp_vs, exp_hs;
    rst_s = 1'b1;
    rst_l = 1'b1;
    cyc = 0;
    for (int c = 0; c <= 339; c++) begin
      if (c > 0) @(negedge clk);
      cyc = c;
      if (c < 336) begin
        if (s_irq === 1'b1) begin irq_cnt++; irq_at = c; end
        exp_vs = !(c >= 243 && c < 291);
        if (s_vs !== exp_vs) vs_err++;
        exp_hs = 1'b1;
        if (c >= 3 && ((c - 3) % 24) >= 18 && ((c - 3) % 24) < 21) exp_hs = 1'b0;
        if (s_hs !== exp_hs) hs_err++;
      end
      for (int k = 0; k <= 10; k++) if (ra_c[k] == c) begin
        tests++; if (s_raddr !== ra_e[k]) begin fails++; $display("FAIL dbuf_addr@%0d: got %h want %h", c, s_raddr, ra_e[k]); end
      end
      for (int k = 0; k <= 5; k++) if (sp_c[k] == c) begin
        tests++; if (s_rgb !== sp_e[k]) begin fails++; $display("FAIL bpc3_pixel@%0d: got %h want %h", c, s_rgb, sp_e[k]); end
      end
      for (int k = 0; k <= 4; k++) if (lp_c[k] == c) begin
        tests++; if (l_rgb !== lp_e[k]) begin fails++; $display("FAIL lat3_pixel@%0d: got %h want %h", c, l_rgb, lp_e[k]); end
      end
      if (c == 31) begin
        tests++; if (l_raddr !== 19'd23) begin fails++; $display("FAIL scale0_addr: got %0d want 23", l_raddr); end
      end
      if (c == 96) s_base = 19'h12C00;
    end
    tests++; if (irq_cnt != 1) begin fails++; $display("FAIL irq_pulses: got %0d want 1", irq_cnt); end
    tests++; if (irq_at != 192) begin fails++; $display("FAIL irq_cycle: got %0d want 192", irq_at); end
    tests++; if (vs_err != 0) begin fails++; $display("FAIL small_vsync: %0d bad cycles, want 0", vs_err); end
    tests++; if (hs_err != 0) begin fails++; $display("FAIL small_hsync: %0d bad cycles, want 0", hs_err); end
  endtask

  task automatic test_enable();
    run_to(340);
    s_en = 1'b0;
    s_bg = 12'hF80;
    run_to(341);
    tests++; if (s_rgb !== 12'hF80) begin fails++; $display("FAIL bg_active_a: got %h want f80", s_rgb); end
    run_to(357);
    tests++; if (s_rgb !== 12'h000) begin fails++; $display("FAIL bg_blank: got %h want 000", s_rgb); end
    run_to(365);
    tests++; if (s_rgb !== 12'hF80) begin fails++; $display("FAIL bg_active_b: got %h want f80", s_rgb); end
    run_to(366);
    s_en = 1'b1;
    run_to(367);
    tests++; if (s_rgb !== 12'hB4B) begin fails++; $display("FAIL reenable_pixel: got %h want b4b", s_rgb); end
  endtask

  task automatic test_reset_midline();
    run_to(461);
    tests++; if (s_rgb !== 12'hB0D) begin fails++; $display("FAIL pre_reset_pixel: got %h want b0d", s_rgb); end
    rst_s = 1'b0;
    #1;
    tests++; if (s_rgb !== 12'h000) begin fails++; $display("FAIL midreset_rgb: got %h want 000", s_rgb); end
    tests++; if (s_hs !== 1'b1 || s_vs !== 1'b1) begin fails++; $display("FAIL midreset_sync: got %b%b want 11", s_hs, s_vs); end
    tests++; if (s_raddr !== 19'd0) begin fails++; $display("FAIL midreset_raddr: got %h want 0", s_raddr); end
    tests++; if (s_irq !== 1'b0) begin fails++; $display("FAIL midreset_irq: got %b want 0", s_irq); end
    @(negedge clk);
    @(negedge clk);
    rst_s = 1'b1;
    cyc = 0;
    tests++; if (s_raddr !== 19'd0) begin fails++; $display("FAIL restart_base: got %h want 0", s_raddr); end
    run_to(3);
    tests++; if (s_rgb !== 12'hB4F) begin fails++; $display("FAIL restart_pixel: got %h want b4f", s_rgb); end
    run_to(20);
    tests++; if (s_hs !== 1'b1) begin fails++; $display("FAIL restart_hs_pre: got %b want 1", s_hs); end
    run_to(21);
    tests++; if (s_hs !== 1'b0) begin fails++; $display("FAIL restart_hs_on: got %b want 0", s_hs); end
    run_to(24);
    tests++; if (s_raddr !== 19'd0) begin fails++; $display("FAIL restart_line1: got %h want 0", s_raddr); end
    run_to(48);
    tests++; if (s_raddr !== 19'd8) begin fails++; $display("FAIL restart_line2: got %h want 8", s_raddr); end
  endtask

  initial begin
    rst_a = 1'b0; rst_s = 1'b0; rst_l = 1'b0;
    a_en = 1'b1; a_bg = 12'h000; a_base = '0;
    s_en = 1'b1; s_bg = 12'h000; s_base = '0;
    l_base = '0;
    test_reset();
    test_default_timing();
    test_double_buffer();
    test_enable();
    test_reset_midline();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
